// File: rtl/signed_mac_stream_if.sv
// Stream bundle for signed_mac_stream: operand beats in, one saturated frame sum out.
interface signed_mac_stream_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/signed_mac_stream.sv
// Framed signed multiply-accumulate: product stage, accumulate stage, then a
// shifted and saturated result held until the consumer takes it.
module signed_mac_stream #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    signed_mac_stream_if.slave    io_bus
);
    localparam int STAGES = 1;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic signed [2*DATA_W-1:0] r_prod;
    logic                       r_p_last;
    logic                       r_p_first;
    logic [STAGES:0]            r_vld_pipe;
    logic                       r_in_frame;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic [OUT_W-1:0]           r_out_data;
    logic                       r_out_sat;
    logic [CNT_W-1:0]           r_out_count;

    logic                       w_accept;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_sh;
    logic [OUT_W-1:0]           w_sat_data;
    logic                       w_sat_flag;

    // in_ready gated by rst_n so it drops the instant reset asserts
    assign io_bus.in_ready  = (r_state == ACCUM) && rst_n;
    assign io_bus.out_valid = (r_state == HOLD);
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_sat   = r_out_sat;
    assign io_bus.out_count = r_out_count;

    assign w_accept   = io_bus.in_valid && io_bus.in_ready;
    assign w_prod     = $signed(io_bus.in_a) * $signed(io_bus.in_b);
    assign w_prod_ext = ACC_W'(r_prod);
    assign w_sh       = r_acc >>> SHIFT;

    always_comb begin
        w_sat_data = w_sh[OUT_W-1:0];
        w_sat_flag = 1'b0;
        if (w_sh > MAXV) begin
            w_sat_data = MAXV[OUT_W-1:0];
            w_sat_flag = 1'b1;
        end else if (w_sh < MINV) begin
            w_sat_data = MINV[OUT_W-1:0];
            w_sat_flag = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && io_bus.in_last) w_next = DRAIN;
            DRAIN:   if (r_vld_pipe[1])              w_next = HOLD;
            HOLD:    if (io_bus.out_ready)           w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod      <= '0;
            r_p_last    <= 1'b0;
            r_p_first   <= 1'b0;
            r_vld_pipe  <= '0;
            r_in_frame  <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0] & r_p_last, w_accept};
            if (w_accept) begin
                r_prod     <= w_prod;
                r_p_last   <= io_bus.in_last;
                r_p_first  <= !r_in_frame;
                r_in_frame <= !io_bus.in_last;
                if (!r_in_frame)  r_cnt <= CNT_W'(1);
                else if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
            end
            if (r_vld_pipe[0]) begin
                if (r_p_first) r_acc <= w_prod_ext;
                else           r_acc <= r_acc + w_prod_ext;
            end
            // the accumulator settled one edge earlier, so the result is final here
            if (r_vld_pipe[1]) begin
                r_out_data  <= w_sat_data;
                r_out_sat   <= w_sat_flag;
                r_out_count <= r_cnt;
            end
        end
    end
endmodule

// File: tb/tb_signed_mac_stream.sv
// Drives a SHIFT=0 and a SHIFT=8 instance with identical streams and checks
// both against an arithmetic model of the frame sum.
module tb_signed_mac_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    signed_mac_stream_if b0 ();
    signed_mac_stream_if b8 ();

    signed_mac_stream #(.SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .io_bus(b0));
    signed_mac_stream #(.SHIFT(8)) dut8 (.clk(clk), .rst_n(rst_n), .io_bus(b8));

    logic [15:0] od [2];
    logic        os [2];
    logic        ov [2];
    logic        ir [2];
    logic [7:0]  oc [2];
    assign od[0] = b0.out_data;  assign od[1] = b8.out_data;
    assign os[0] = b0.out_sat;   assign os[1] = b8.out_sat;
    assign ov[0] = b0.out_valid; assign ov[1] = b8.out_valid;
    assign ir[0] = b0.in_ready;  assign ir[1] = b8.in_ready;
    assign oc[0] = b0.out_count; assign oc[1] = b8.out_count;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] fa [$];
    logic [15:0] fb [$];
    int          fgap [$];

    function automatic void model(input longint sum, input int sh,
                                  output logic [15:0] d, output logic s);
        longint acc, v;
        acc = (sum <<< 24) >>> 24;
        v = acc >>> sh;
        if (v > 32767)       begin d = 16'h7FFF; s = 1'b1; end
        else if (v < -32768) begin d = 16'h8000; s = 1'b1; end
        else                 begin d = v[15:0];  s = 1'b0; end
    endfunction

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic l);
        b0.in_valid = v; b0.in_a = a; b0.in_b = b; b0.in_last = l;
        b8.in_valid = v; b8.in_a = a; b8.in_b = b; b8.in_last = l;
    endtask

    task automatic set_oready(input logic r);
        b0.out_ready = r;
        b8.out_ready = r;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic l);
        @(negedge clk);
        drive(1'b1, a, b, l);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (ir[d] !== 1'b1) $display("FAIL beat_in_ready dut%0d got %b want 1", d, ir[d]);
            else n_pass++;
        end
        @(posedge clk);
        #1 drive(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic collect(input longint sum, input int n, input int hold);
        logic [15:0] ed [2];
        logic        es [2];
        logic [7:0]  ec;
        int          cyc;
        model(sum, 0, ed[0], es[0]);
        model(sum, 8, ed[1], es[1]);
        ec = (n > 255) ? 8'd255 : 8'(n);
        cyc = 0;
        while (!ov[0] && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_chk++;
        if (cyc !== 2) $display("FAIL latency got %0d edges want 2", cyc);
        else n_pass++;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (ov[d] !== 1'b1) $display("FAIL out_valid dut%0d got %b want 1", d, ov[d]);
            else n_pass++;
            n_chk++;
            if (od[d] !== ed[d]) $display("FAIL out_data dut%0d got %h want %h", d, od[d], ed[d]);
            else n_pass++;
            n_chk++;
            if (os[d] !== es[d]) $display("FAIL out_sat dut%0d got %b want %b", d, os[d], es[d]);
            else n_pass++;
            n_chk++;
            if (oc[d] !== ec) $display("FAIL out_count dut%0d got %0d want %0d", d, oc[d], ec);
            else n_pass++;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (ir[d] !== 1'b0 || ov[d] !== 1'b1 || od[d] !== ed[d])
                    $display("FAIL hold dut%0d cyc%0d ready=%b valid=%b data=%h want ready=0 valid=1 data=%h",
                             d, h, ir[d], ov[d], od[d], ed[d]);
                else n_pass++;
            end
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        set_oready(1'b1);
        @(posedge clk); #1;
        set_oready(1'b0);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b1)
                $display("FAIL release dut%0d valid=%b ready=%b want valid=0 ready=1", d, ov[d], ir[d]);
            else n_pass++;
        end
    endtask

    task automatic run_frame(input int hold);
        longint sum = 0;
        int n = fa.size();
        for (int i = 0; i < n; i++) begin
            repeat (fgap[i]) @(posedge clk);
            beat(fa[i], fb[i], i == n - 1);
            sum += longint'($signed(fa[i])) * longint'($signed(fb[i]));
        end
        collect(sum, n, hold);
        fa.delete(); fb.delete(); fgap.delete();
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input int g);
        fa.push_back(a); fb.push_back(b); fgap.push_back(g);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (ov[d] !== 1'b0 || ir[d] !== 1'b0 || od[d] !== 16'h0 || os[d] !== 1'b0 || oc[d] !== 8'h0)
                $display("FAIL %s dut%0d valid=%b ready=%b data=%h sat=%b count=%0d want all 0",
                         tag, d, ov[d], ir[d], od[d], os[d], oc[d]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        set_oready(1'b0);
        rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single();
        push(16'hFFFB, 16'h0003, 0);
        run_frame(0);
    endtask

    task automatic test_gap();
        push(16'hFFFB, 16'h0003, 0);
        push(16'h0007, 16'h0002, 1);
        push(16'h0064, 16'hFFFF, 0);
        run_frame(0);
    endtask

    task automatic test_saturation();
        push(16'h7FFF, 16'h7FFF, 0); push(16'h7FFF, 16'h7FFF, 0); run_frame(0);
        push(16'h8000, 16'h7FFF, 0); run_frame(0);
        push(16'h8000, 16'h8000, 0); run_frame(0);
    endtask

    task automatic test_shift();
        push(16'h0100, 16'h0300, 0);
        run_frame(0);
    endtask

    task automatic test_hold();
        push(16'h1234, 16'h0002, 0);
        push(16'hF000, 16'h0003, 2);
        run_frame(5);
    endtask

    task automatic test_reset_mid();
        beat(16'h0011, 16'h0022, 1'b0);
        beat(16'h0033, 16'h0044, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid");
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        push(16'h0002, 16'h0003, 0);
        run_frame(0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                push(16'($urandom), 16'($urandom), (i == 0) ? 0 : $urandom_range(0, 2));
            run_frame($urandom_range(0, 3));
        end
        for (int i = 0; i < 260; i++)
            push(16'($urandom_range(0, 200)), 16'($urandom_range(0, 50)), 0);
        run_frame(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_saturation();
        test_shift();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/signed_mac_stream.md
SIGNED_MAC_STREAM -- requirements
Module: signed_mac_stream

Interface
REQ-001 Parameter DATA_W, default 16: signed width of each operand.
REQ-002 Parameter ACC_W, default 40: signed accumulator width, SHALL be >= 2*DATA_W.
REQ-003 Parameter OUT_W, default 16: signed result width, SHALL be <= ACC_W.
REQ-004 Parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation, 0 <= SHIFT < ACC_W.
REQ-005 Parameter CNT_W, default 8: beat-counter width.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port in_valid, input, 1: producer presents a beat.
REQ-009 Port in_ready, output, 1: block accepts a beat when in_valid && in_ready at a rising edge.
REQ-010 Port in_a, input, DATA_W: signed two's-complement operand A.
REQ-011 Port in_b, input, DATA_W: signed two's-complement operand B.
REQ-012 Port in_last, input, 1: marks the final beat of a frame.
REQ-013 Port out_valid, output, 1: frame result is available.
REQ-014 Port out_ready, input, 1: consumer takes the result when out_valid && out_ready at a rising edge.
REQ-015 Port out_data, output, OUT_W: saturated, shifted frame sum.
REQ-016 Port out_sat, output, 1: high when out_data was clipped.
REQ-017 Port out_count, output, CNT_W: number of beats in the frame, saturating at 2^CNT_W-1.

Function
REQ-018 States: ACCUM accepts beats; DRAIN flushes the pipeline; HOLD presents the result.
REQ-019 in_ready SHALL be 1 only in ACCUM and 0 while rst_n is low.
REQ-020 Stage 1: on an accepted beat at edge k, the block SHALL register the full-precision signed product a*b (2*DATA_W bits) together with its last flag and first-of-frame flag.
REQ-021 Stage 2, edge k+1: the accumulator SHALL load the sign-extended product when the beat is first of its frame, otherwise it adds the product, wrapping modulo 2^ACC_W.
REQ-022 An accepted in_last SHALL move the FSM from ACCUM to DRAIN at edge k; no further beats are accepted.
REQ-023 At edge k+2 the block SHALL load out_data = sat_OUT_W(acc >>> SHIFT) and out_count, set out_sat, assert out_valid, and enter HOLD.
REQ-024 Saturation SHALL clip to +(2^(OUT_W-1)-1) or -2^(OUT_W-1), with out_sat=1 iff clipped.
REQ-025 In HOLD, out_data, out_sat and out_count SHALL stay stable until handshake; on out_valid && out_ready, out_valid drops and the FSM returns to ACCUM at that edge.
REQ-026 The beat counter SHALL reset to 0 at each frame start and increment per accepted beat, saturating at 2^CNT_W-1.
REQ-027 A single-beat frame (in_last on the first beat) SHALL yield sat(a*b >>> SHIFT) with out_count=1.
REQ-028 A gap cycle (in_valid=0) in ACCUM SHALL leave the accumulator and counter unchanged.

Reset
REQ-029 While rst_n is low: state=ACCUM, the accumulator, pipeline registers, counter, out_data, out_sat and out_count are 0, and out_valid=0, all asynchronously.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial frame and pending result; the first beat after release starts a new frame.

Verification
REQ-031 Defaults; single beat a=0xFFFB, b=0x0003, last -> out_valid at edge k+2, out_data=0xFFF1, out_count=1, out_sat=0.
REQ-032 Defaults; frame (-5,3),(7,2),(100,-1 i.e. 0xFFFF) with a gap cycle between beats 1 and 2 -> out_data=0xFF9B (-101), out_count=3, out_sat=0.
REQ-033 Defaults; frames (0x7FFF,0x7FFF)x2 -> out_data=0x7FFF, out_sat=1; (0x8000,0x7FFF) -> 0x8000, out_sat=1; (0x8000,0x8000) -> 0x7FFF, out_sat=1.
REQ-034 SHIFT=8; single beat (0x0100,0x0300) -> out_data=0x0300, out_sat=0.
REQ-035 out_ready held low for 5 cycles after out_valid -> out_data constant, in_ready=0 and in_valid ignored throughout; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
REQ-036 rst_n pulsed low after 2 beats of a frame -> all outputs 0 immediately; next frame (2,3),last -> out_data=0x0006, out_count=1.
